cheby_stream_driver: RTL

- Initiator side of the valid/ready interface on the BF16 Chebyshev exp unit.
- Accepts a packetised stream of BF16 operands from upstream and buffers them in an operand FIFO.
- Issues operands to the exp unit, collects its results in order, and re-emits them as a packetised stream with packet boundaries preserved.
- Sits between the vector datapath (e.g. softmax front end) and one exp responder.

---
 rtl/cheby_stream_driver_if.sv | 29 ++
 rtl/cheby_stream_driver.sv | 116 +++++++++++
 2 files changed

// File: rtl/cheby_stream_driver_if.sv
// rtl/cheby_stream_driver_if.sv - stream, exp request/response and status signals of the exp stream driver
interface cheby_stream_driver_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        err;

    modport master (
        input  s_valid, s_data, s_last, req_ready, resp_valid, resp_data, m_ready,
        output s_ready, req_valid, req_data, resp_ready, m_valid, m_data, m_last, busy, err
    );

    modport slave (
        output s_valid, s_data, s_last, req_ready, resp_valid, resp_data, m_ready,
        input  s_ready, req_valid, req_data, resp_ready, m_valid, m_data, m_last, busy, err
    );
endinterface

// File: rtl/cheby_stream_driver.sv
// rtl/cheby_stream_driver.sv - operand FIFO, in-order issue with last-bit tags, and result register for the BF16 exp unit
module cheby_stream_driver #(
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cheby_stream_driver_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [OW-1:0] OUT_ONE  = OW'(1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);
    localparam logic [TW-1:0] TAG_ONE  = TW'(1);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUT - 1);

    logic [16:0]   fifo_mem [DEPTH];
    logic          tag_mem  [MAX_OUT];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          out_full_q, out_full_d;
    logic          out_last_q, out_last_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          err_q, err_d;
    logic          live_q;

    logic fifo_empty, fifo_full;
    logic push, issue, resp_fire, resp_take, m_fire;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // live_q keeps both ready outputs low until the first clock after reset release
    assign bus.s_ready    = live_q && !fifo_full;
    assign bus.req_valid  = !fifo_empty && (outstanding_q < OUT_MAX);
    assign bus.req_data   = bus.req_valid ? fifo_mem[rd_ptr_q[AW-1:0]][15:0] : 16'h0000;
    assign bus.resp_ready = live_q && (!out_full_q || bus.m_ready);
    assign bus.m_valid    = out_full_q;
    assign bus.m_data     = out_data_q;
    assign bus.m_last     = out_last_q;
    assign bus.busy       = !fifo_empty || (outstanding_q != '0) || out_full_q;
    assign bus.err        = err_q;

    assign push      = bus.s_valid && bus.s_ready;
    assign issue     = bus.req_valid && bus.req_ready;
    assign resp_fire = bus.resp_valid && bus.resp_ready;
    assign resp_take = resp_fire && (outstanding_q != '0);
    assign m_fire    = bus.m_valid && bus.m_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q;
        out_full_d    = out_full_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        err_d         = err_q || (resp_fire && (outstanding_q == '0));

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TAG_ONE;
        end
        if (resp_take) tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TAG_ONE;

        if (issue && !resp_take)      outstanding_d = outstanding_q + OUT_ONE;
        else if (!issue && resp_take) outstanding_d = outstanding_q - OUT_ONE;

        // A response in the same cycle as a downstream handshake reloads without a bubble
        if (resp_take) begin
            out_full_d = 1'b1;
            out_data_d = bus.resp_data;
            out_last_d = tag_mem[tag_rd_q];
        end else if (m_fire) begin
            out_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            outstanding_q <= '0;
            out_full_q    <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            err_q         <= 1'b0;
            live_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            outstanding_q <= outstanding_d;
            out_full_q    <= out_full_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            err_q         <= err_d;
            live_q        <= 1'b1;
        end
    end

    // Storage only; validity is tracked by the reset pointers above
    always_ff @(posedge clk) begin
        if (push)  fifo_mem[wr_ptr_q[AW-1:0]] <= {bus.s_last, bus.s_data};
        if (issue) tag_mem[tag_wr_q]          <= fifo_mem[rd_ptr_q[AW-1:0]][16];
    end
endmodule
